// File: rtl/alici_verici_carpici_pkg.sv
// Shared constants for the bit-serial receive/multiply/transmit block.
// Frame layout is derived entirely from the operand width W.
package alici_verici_carpici_pkg;

  localparam int W_DEFAULT = 3;

  // Slot boundaries as functions of an arbitrary width, so a top-level
  // override of W keeps the whole frame map consistent.
  function automatic int frame_len(input int w);
    return 3 * w + 2;
  endfunction

  function automatic int rx_last(input int w);
    return 2 * w - 1;
  endfunction

  function automatic int idle_slot(input int w);
    return 2 * w;
  endfunction

  function automatic int mul_slot(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int tx_first(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int tx_last(input int w);
    return 3 * w + 1;
  endfunction

  localparam int FRAME_LEN = frame_len(W_DEFAULT);
  localparam int RX_LAST   = rx_last(W_DEFAULT);
  localparam int IDLE_SLOT = idle_slot(W_DEFAULT);
  localparam int MUL_SLOT  = mul_slot(W_DEFAULT);
  localparam int TX_FIRST  = tx_first(W_DEFAULT);
  localparam int TX_LAST   = tx_last(W_DEFAULT);

  // Frame phase decoded from the slot counter.
  typedef enum logic [1:0] {
    PH_RX   = 2'd0,
    PH_IDLE = 2'd1,
    PH_MUL  = 2'd2,
    PH_TX   = 2'd3
  } phase_e;

endpackage

// File: rtl/alici_verici_carpici_carpici.sv
// Combinational multiplier returning the product truncated to W bits.
module carpici
  import alici_verici_carpici_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  // Operands and result are all W bits wide, so the multiply is evaluated
  // at W bits and the upper product bits fall away naturally.
  assign p = a * b;

endmodule

// File: rtl/alici_verici_carpici.sv
// Bit-serial receive/multiply/transmit block. A free-running frame shifts
// two W-bit operands in on rx (MSB first), multiplies them, and shifts the
// W-bit truncated product out on tx (MSB first). Frame alignment comes only
// from reset release: the first edge after rst_n rises is slot 0.
module alici_verici_carpici
  import alici_verici_carpici_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic tx
);

  localparam int FL = frame_len(W);
  localparam int SW = $clog2(FL);
  localparam int IW = (W > 2) ? $clog2(W) : 1;

  localparam logic [SW-1:0] S_LAST     = SW'(FL - 1);
  localparam logic [SW-1:0] S_RX_LAST  = SW'(rx_last(W));
  localparam logic [SW-1:0] S_MUL      = SW'(mul_slot(W));
  localparam logic [SW-1:0] S_TX_FIRST = SW'(tx_first(W));
  localparam logic [SW-1:0] S_TX_LAST  = SW'(tx_last(W));

  logic [SW-1:0]  slot;
  logic [2*W-1:0] sr;
  logic [W-1:0]   prod;
  logic [W-1:0]   p;
  phase_e         phase;
  logic [IW-1:0]  bit_idx;

  carpici #(.W(W)) u_carpici (
    .a (sr[2*W-1:W]),
    .b (sr[W-1:0]),
    .p (p)
  );

  // Decode the current slot into its frame phase.
  always_comb begin
    phase = PH_IDLE;
    if (slot <= S_RX_LAST)       phase = PH_RX;
    else if (slot == S_MUL)      phase = PH_MUL;
    else if (slot >= S_TX_FIRST) phase = PH_TX;
  end

  // Product bit to present next: the edge ending slot TX_FIRST+k loads bit W-2-k.
  always_comb begin
    bit_idx = IW'(W - 2 - int'(slot - S_TX_FIRST));
  end

  // Free-running slot counter, wrapping at the end of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              slot <= '0;
    else if (slot == S_LAST) slot <= '0;
    else                     slot <= slot + SW'(1);
  end

  // Shift rx in MSB first during receive slots; A lands in the upper half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               sr <= '0;
    else if (phase == PH_RX)  sr <= {sr[2*W-2:0], rx};
  end

  // Capture the product once per frame and serialise it onto tx; the first
  // bit comes straight from the multiplier so tx is valid in TX_FIRST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      tx   <= 1'b0;
    end else if (phase == PH_MUL) begin
      prod <= p;
      tx   <= p[W-1];
    end else if (phase == PH_TX && slot != S_TX_LAST) begin
      tx   <= prod[bit_idx];
    end else begin
      tx   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alici_verici_carpici.sv
// Self-checking bench for alici_verici_carpici. The expected tx stream is
// derived from the frame map and plain integer multiplication.
module tb_alici_verici_carpici;

  localparam int W  = 3;
  localparam int FL = 3 * W + 2;

  logic clk;
  logic rst_n;
  logic rx;
  logic tx;

  int n_cmp = 0;
  int n_err = 0;

  alici_verici_carpici #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .tx    (tx)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: tx expected during slot s of a frame carrying operands a, b.
  function automatic logic exp_tx(input int a, input int b, input int s);
    int prod;
    prod = (a * b) % (1 << W);
    if (s >= 2 * W + 2 && s <= 3 * W + 1) return 1'((prod >> (3 * W + 1 - s)) & 1);
    return 1'b0;
  endfunction

  // Drive one frame starting at slot 0 (bench sits at a negedge). Slots
  // below 'stop' are run; for each, tx is checked and rx driven before
  // the edge ending that slot. Returns positioned at the negedge of 'stop'.
  task automatic run_frame(input int a, input int b, input bit noisy,
                           input int stop, input string tag);
    logic e;
    for (int s = 0; s < stop; s++) begin
      e = exp_tx(a, b, s);
      n_cmp++;
      if (tx !== e) begin
        n_err++;
        $display("FAIL %s slot %0d: tx=%b expected %b", tag, s, tx, e);
      end
      if (s < W)          rx = 1'((a >> (W - 1 - s)) & 1);
      else if (s < 2 * W) rx = 1'((b >> (2 * W - 1 - s)) & 1);
      else                rx = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b0;
    #2;
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: tx=%b expected 0", tx);
    end
    for (int i = 0; i < 3; i++) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: tx=%b expected 0", tx);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_frame(3, 2, 1'b0, FL, "a3_b2");
    run_frame(7, 7, 1'b0, FL, "a7_b7");
  endtask

  task automatic test_back_to_back_rx_ignored();
    run_frame(0, 5, 1'b1, FL, "a0_b5_noisy");
    run_frame(5, 1, 1'b1, FL, "a5_b1_noisy");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                1'b1, FL, "random");
    end
  endtask

  task automatic test_reset_mid_frame();
    run_frame(6, 6, 1'b1, 4, "pre_mid_reset");
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_async: tx=%b expected 0", tx);
    end
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_hold: tx=%b expected 0", tx);
    end
    rst_n = 1'b1;
    run_frame(2, 3, 1'b1, FL, "a2_b3_after_reset");
  endtask

  task automatic test_reset_during_tx();
    run_frame(7, 1, 1'b0, 9, "pre_tx_reset");
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL tx_slot9_before_reset: tx=%b expected 1", tx);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL tx_reset_async: tx=%b expected 0", tx);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b0) begin
        n_err++;
        $display("FAIL tx_reset_hold: tx=%b expected 0", tx);
      end
    end
    rst_n = 1'b1;
    run_frame(3, 3, 1'b1, FL, "a3_b3_after_tx_reset");
    run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              1'b1, FL, "random_after_tx_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_rx_ignored();
    test_random();
    test_reset_mid_frame();
    test_reset_during_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
